// File: rtl/syncram_1rw1r_be.sv
`default_nettype none
// =============================================================================
// syncram_1rw1r_be : 1RW + 1R byte-enable RAM, read-during-write forwarding,
// power-up clear to INIT_VAL. Optional macro SYNCRAM_PARITY_EN. Rev 1.0
// =============================================================================
module syncram_1rw1r_be #(
  parameter int unsigned    DBW      = 8,
  parameter int unsigned    AW       = 12,
  parameter logic [DBW-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wce,
  input  logic [DBW/8-1:0] we,
  input  logic [AW-1:0]    wadr,
  input  logic [DBW-1:0]   i,
  output logic [DBW-1:0]   wo,
  input  logic             rce,
  input  logic [AW-1:0]    radr,
  output logic [DBW-1:0]   o,
  output logic             busy,
  output logic             perr
);

  localparam int unsigned NB    = DBW / 8;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef SYNCRAM_PARITY_EN
  localparam int unsigned MW    = DBW + NB;
`else
  localparam int unsigned MW    = DBW;
`endif

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;

  logic           w_run, w_rd_a, w_rd_b;
  logic           mem_we;
  logic [AW-1:0]  mem_adr;
  logic [DBW-1:0] mem_din;
  logic [NB-1:0]  mem_be;

  logic [MW-1:0]  mem [DEPTH];
  logic [DBW-1:0] ram_a_q;
  logic [MW-1:0]  ram_b_q;

  // Side registers carry the write data/lane masks needed to merge after the array.
  logic           a_vld_q, b_vld_q;
  logic [NB-1:0]  a_we_q, b_fwd_q;
  logic [DBW-1:0] a_dat_q, b_dat_q;
  logic [DBW-1:0] w_wo, w_o;

`ifdef SYNCRAM_PARITY_EN
  function automatic logic [NB-1:0] lane_par(input logic [DBW-1:0] d);
    logic [NB-1:0] p;
    for (int n = 0; n < NB; n++) p[n] = ^d[8*n +: 8];
    return p;
  endfunction

  logic [NB-1:0] w_par;
  assign w_par = lane_par(mem_din);
`endif

  assign w_run  = (state_q == S_RUN) && !rst;
  assign w_rd_a = w_run && wce;
  assign w_rd_b = w_run && rce;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = S_RUN;
    end
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_adr = wadr;
    mem_din = i;
    mem_be  = we;
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem_we  = 1'b1;
        mem_adr = cnt_q;
        mem_din = INIT_VAL;
        mem_be  = '1;
      end else if (wce) begin
        mem_we  = |we;
      end
    end
  end

  // Plain array with registered reads: old-data semantics, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int n = 0; n < NB; n++) begin
        if (mem_be[n]) begin
          mem[mem_adr][8*n +: 8] <= mem_din[8*n +: 8];
`ifdef SYNCRAM_PARITY_EN
          mem[mem_adr][DBW+n] <= w_par[n];
`endif
        end
      end
    end
    if (w_rd_a) ram_a_q <= mem[wadr][DBW-1:0];
    if (w_rd_b) ram_b_q <= mem[radr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      a_we_q  <= '0;
      a_dat_q <= '0;
      b_fwd_q <= '0;
      b_dat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_rd_a) begin
        a_vld_q <= 1'b1;
        a_we_q  <= we;
        a_dat_q <= i;
      end
      if (w_rd_b) begin
        b_vld_q <= 1'b1;
        b_fwd_q <= (wce && (radr == wadr)) ? we : '0;
        b_dat_q <= i;
      end
    end
  end

  always_comb begin
    w_wo = ram_a_q;
    w_o  = ram_b_q[DBW-1:0];
    for (int n = 0; n < NB; n++) begin
      if (a_we_q[n])  w_wo[8*n +: 8] = a_dat_q[8*n +: 8];
      if (b_fwd_q[n]) w_o[8*n +: 8]  = b_dat_q[8*n +: 8];
    end
  end

  assign wo   = a_vld_q ? w_wo : '0;
  assign o    = b_vld_q ? w_o  : '0;
  assign busy = rst || (state_q == S_CLEAR);

`ifdef SYNCRAM_PARITY_EN
  // Forwarded lanes carry fresh data, so their stored parity is irrelevant.
  logic [NB-1:0] w_bad;
  assign w_bad = (lane_par(ram_b_q[DBW-1:0]) ^ ram_b_q[MW-1:DBW]) & ~b_fwd_q;
  assign perr  = b_vld_q && (|w_bad);
`else
  assign perr  = 1'b0;
`endif

endmodule
`default_nettype wire
